// File: rtl/deserializer_pkg.sv
// Shared types and helpers for the deserializer block.
package deserializer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Counter width for an index range 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/deserializer_control.sv
// Frame FSM and word counter for the deserializer.
// DESERIALIZER_PIPELINE_EN lets the first word of the next frame enter during the send fire.
module deserializer_control
  import deserializer_pkg::*;
#(
  parameter int N_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [N_SAMPLES-1:0] wr_en
);

  localparam int CNT_W = cnt_width(N_SAMPLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  state_e           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             recv_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    recv_rdy   = 1'b0;
    send_val   = 1'b0;
    wr_en      = '0;
    recv_fire  = 1'b0;
    case (state)
      COLLECT: begin
        // Gated by reset so rdy is low while reset is held.
        recv_rdy  = reset;
        recv_fire = recv_val && recv_rdy;
        if (recv_fire) begin
          wr_en[count] = 1'b1;
          if (count == LAST) begin
            count_next = '0;
            state_next = HOLD;
          end else begin
            count_next = count + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        send_val = 1'b1;
`ifdef DESERIALIZER_PIPELINE_EN
        recv_rdy  = send_rdy;
        recv_fire = recv_val && recv_rdy;
        if (recv_fire) begin
          wr_en[0]   = 1'b1;
          count_next = CNT_W'(1);
        end
`endif
        if (send_rdy) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel frame assembler: N_SAMPLES words in, one frame out.
// Optional macro DESERIALIZER_PIPELINE_EN removes the bubble between frames.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0],
  output logic                 send_val,
  input  logic                 send_rdy
);

  logic [N_SAMPLES-1:0] wr_en;
  logic [BIT_WIDTH-1:0] samples_p0 [N_SAMPLES-1:0];

  deserializer_control #(
    .N_SAMPLES(N_SAMPLES)
  ) u_control (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .wr_en    (wr_en)
  );

  // Sample registers: one-hot write enable, output driven straight from storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SAMPLES; i++) samples_p0[i] <= '0;
    end else begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        if (wr_en[i]) samples_p0[i] <= recv_msg;
      end
    end
  end

  assign send_msg = samples_p0;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: default 8x32 instance plus a 5x8 instance.
module tb_deserializer;

`ifdef DESERIALIZER_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] recv_msg;
  logic        recv_val;
  logic        recv_rdy;
  logic [31:0] send_msg [7:0];
  logic        send_val;
  logic        send_rdy;

  logic [7:0]  recv_msg5;
  logic        recv_val5;
  logic        recv_rdy5;
  logic [7:0]  send_msg5 [4:0];
  logic        send_val5;
  logic        send_rdy5;

  int errors = 0;
  int checks = 0;

  deserializer #(.BIT_WIDTH(32), .N_SAMPLES(8)) dut (
    .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_val(recv_val),
    .recv_rdy(recv_rdy), .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy)
  );

  deserializer #(.BIT_WIDTH(8), .N_SAMPLES(5)) dut5 (
    .clk(clk), .reset(reset), .recv_msg(recv_msg5), .recv_val(recv_val5),
    .recv_rdy(recv_rdy5), .send_msg(send_msg5), .send_val(send_val5), .send_rdy(send_rdy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    recv_val = 1'b1;
    recv_msg = d;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; recv_val = 1'b0; recv_msg = '0; send_rdy = 1'b1;
    recv_val5 = 1'b0; recv_msg5 = '0; send_rdy5 = 1'b1;
    #2;
    checks++;
    if (send_val !== 1'b0) begin errors++; $display("FAIL reset_send_val: got %b expected 0", send_val); end
    checks++;
    if (recv_rdy !== 1'b0) begin errors++; $display("FAIL reset_recv_rdy: got %b expected 0", recv_rdy); end
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (send_msg[i] !== 32'h0) begin errors++; $display("FAIL reset_msg[%0d]: got %h expected 0", i, send_msg[i]); end
    end
    checks++;
    if (recv_rdy !== 1'b0) begin errors++; $display("FAIL reset_recv_rdy_held: got %b expected 0", recv_rdy); end
    reset = 1'b1;
    #1;
    checks++;
    if (recv_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_recv_rdy: got %b expected 1", recv_rdy); end
    checks++;
    if (send_val !== 1'b0) begin errors++; $display("FAIL post_reset_send_val: got %b expected 0", send_val); end
  endtask

  task automatic test_basic();
    send_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_word(32'h10 + i);
      checks++;
      if (send_val !== (i == 7)) begin errors++; $display("FAIL basic_send_val word %0d: got %b expected %b", i, send_val, (i == 7)); end
    end
    recv_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (send_msg[i] !== 32'h10 + i) begin errors++; $display("FAIL basic_msg[%0d]: got %h expected %h", i, send_msg[i], 32'h10 + i); end
    end
    checks++;
    if (recv_rdy !== PIPE) begin errors++; $display("FAIL basic_hold_recv_rdy: got %b expected %b", recv_rdy, PIPE); end
    tick();
    checks++;
    if (send_val !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", send_val); end
    checks++;
    if (recv_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy_after: got %b expected 1", recv_rdy); end
  endtask

  task automatic test_gaps();
    send_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_word(32'hA0 + i);
      checks++;
      if (send_val !== (i == 7)) begin errors++; $display("FAIL gaps_send_val fire %0d: got %b expected %b", i, send_val, (i == 7)); end
      if (i < 7) begin
        recv_val = 1'b0;
        recv_msg = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (send_val !== 1'b0) begin errors++; $display("FAIL gaps_idle %0d: got %b expected 0", i, send_val); end
      end
    end
    recv_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (send_msg[i] !== 32'hA0 + i) begin errors++; $display("FAIL gaps_msg[%0d]: got %h expected %h", i, send_msg[i], 32'hA0 + i); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    send_rdy = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h30 + i);
    recv_val = 1'b1;
    recv_msg = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (send_val !== 1'b1) begin errors++; $display("FAIL bp_send_val cycle %0d: got %b expected 1", c, send_val); end
      checks++;
      if (recv_rdy !== 1'b0) begin errors++; $display("FAIL bp_recv_rdy cycle %0d: got %b expected 0", c, recv_rdy); end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (send_msg[i] !== 32'h30 + i) begin errors++; $display("FAIL bp_msg[%0d] cycle %0d: got %h expected %h", i, c, send_msg[i], 32'h30 + i); end
      end
      tick();
    end
    recv_val = 1'b0;
    send_rdy = 1'b1;
    tick();
    checks++;
    if (send_val !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", send_val); end
    checks++;
    if (recv_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %b expected 1", recv_rdy); end
  endtask

  task automatic test_back_to_back();
    int idx = 0, cyc = 0, nfr = 0, first_cyc = 0, second_cyc = 0;
    logic fire;
    send_rdy = 1'b1;
    recv_val = 1'b1;
    recv_msg = 32'd0;
    while (nfr < 2 && cyc < 40) begin
      fire = recv_val && recv_rdy;
      tick();
      cyc++;
      if (fire) idx++;
      if (send_val) begin
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (send_msg[i] !== 32'(nfr * 8 + i)) begin errors++; $display("FAIL b2b_frame%0d_msg[%0d]: got %h expected %h", nfr, i, send_msg[i], nfr * 8 + i); end
        end
        if (nfr == 0) first_cyc = cyc; else second_cyc = cyc;
        nfr++;
      end
      recv_val = (idx < 16);
      recv_msg = 32'(idx);
    end
    recv_val = 1'b0;
    checks++;
    if (nfr != 2) begin errors++; $display("FAIL b2b_frames: got %0d expected 2", nfr); end
    checks++;
    if (first_cyc != 8) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 8", first_cyc); end
    checks++;
    if (second_cyc - first_cyc != (PIPE ? 8 : 9)) begin
      errors++; $display("FAIL b2b_period: got %0d expected %0d", second_cyc - first_cyc, PIPE ? 8 : 9);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    send_rdy = 1'b1;
    for (int i = 0; i < 3; i++) push_word(32'h50 + i);
    recv_val = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (send_val !== 1'b0) begin errors++; $display("FAIL mid_reset_send_val: got %b expected 0", send_val); end
    checks++;
    if (recv_rdy !== 1'b0) begin errors++; $display("FAIL mid_reset_recv_rdy: got %b expected 0", recv_rdy); end
    checks++;
    if (send_msg[0] !== 32'h0) begin errors++; $display("FAIL mid_reset_clear: got %h expected 0", send_msg[0]); end
    tick();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      push_word(32'h20 + i);
      checks++;
      if (send_val !== (i == 7)) begin errors++; $display("FAIL mid_send_val word %0d: got %b expected %b", i, send_val, (i == 7)); end
    end
    recv_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (send_msg[i] !== 32'h20 + i) begin errors++; $display("FAIL mid_msg[%0d]: got %h expected %h", i, send_msg[i], 32'h20 + i); end
    end
    send_rdy = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (send_val !== 1'b0) begin errors++; $display("FAIL hold_reset_send_val: got %b expected 0", send_val); end
    tick();
    reset = 1'b1;
    send_rdy = 1'b1;
    #1;
  endtask

  task automatic test_n5();
    send_rdy5 = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 5; i++) begin
        recv_val5 = 1'b1;
        recv_msg5 = 8'(f * 5 + i + 1);
        tick();
        checks++;
        if (send_val5 !== (i == 4)) begin errors++; $display("FAIL n5_send_val f%0d w%0d: got %b expected %b", f, i, send_val5, (i == 4)); end
      end
      recv_val5 = 1'b0;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (send_msg5[i] !== 8'(f * 5 + i + 1)) begin errors++; $display("FAIL n5_msg f%0d [%0d]: got %h expected %h", f, i, send_msg5[i], f * 5 + i + 1); end
      end
      tick();
      checks++;
      if (send_val5 !== 1'b0) begin errors++; $display("FAIL n5_drain f%0d: got %b expected 0", f, send_val5); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_n5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
